// File: rtl/reservation_station.sv
// Age-ordered reservation station with busy-table wakeup and oldest-ready issue.
// Optional RS_WAKEUP_BYPASS_EN lets a same-cycle wakeup feed issue selection.
module reservation_station #(
  parameter int DEPTH     = 8,
  parameter int NUM_PREGS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [5:0]  in_ps1,
  input  logic [5:0]  in_ps2,
  input  logic [5:0]  in_pd,
  input  logic [31:0] in_instr,
  input  logic        wb_valid,
  input  logic [5:0]  wb_preg,
  output logic        iss_valid,
  input  logic        iss_ready,
  output logic [6:0]  iss_opcode,
  output logic [5:0]  iss_ps1,
  output logic [5:0]  iss_ps2,
  output logic [5:0]  iss_pd,
  output logic [31:0] iss_instr,
  input  logic        flush,
  output logic [4:0]  count
);

  typedef struct packed {
    logic [6:0]  op;
    logic [5:0]  ps1;
    logic [5:0]  ps2;
    logic [5:0]  pd;
    logic [31:0] instr;
    logic        r1;
    logic        r2;
  } ent_t;

  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  ent_t                 ent_q [DEPTH];
  ent_t                 ent_d [DEPTH];
  ent_t                 ent_w [DEPTH+1];
  ent_t                 new_e;
  logic [4:0]           cnt_q, cnt_d, cnt_post;
  logic [NUM_PREGS-1:0] busy_q, busy_d;
  logic [DEPTH-1:0]     rdy;
  logic [4:0]           sel;
  logic                 in_fire, iss_fire;

  function automatic logic no_rs1(input logic [6:0] op);
    return op inside {7'b0110111, 7'b0010111, 7'b1101111};
  endfunction

  function automatic logic no_rs2(input logic [6:0] op);
    return no_rs1(op) ||
      (op inside {7'b0010011, 7'b0000011, 7'b1100111});
  endfunction

  function automatic logic has_rd(input logic [6:0] op);
    return !(op inside {7'b0100011, 7'b1100011});
  endfunction

  // Resident entries with this cycle's wakeup folded in; extra slot feeds the tail shift
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_w[i] = ent_q[i];
      if (wb_valid && ent_q[i].ps1 == wb_preg)
        ent_w[i].r1 = 1'b1;
      if (wb_valid && ent_q[i].ps2 == wb_preg)
        ent_w[i].r2 = 1'b1;
    end
    ent_w[DEPTH] = '0;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
      rdy[i] = (5'(i) < cnt_q) && ent_w[i].r1 && ent_w[i].r2;
`else
      rdy[i] = (5'(i) < cnt_q) && ent_q[i].r1 && ent_q[i].r2;
`endif
    end
  end

  always_comb begin
    iss_valid  = 1'b0;
    sel        = '0;
    iss_opcode = '0;
    iss_ps1    = '0;
    iss_ps2    = '0;
    iss_pd     = '0;
    iss_instr  = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (rdy[i]) begin
        iss_valid  = 1'b1;
        sel        = 5'(i);
        iss_opcode = ent_q[i].op;
        iss_ps1    = ent_q[i].ps1;
        iss_ps2    = ent_q[i].ps2;
        iss_pd     = ent_q[i].pd;
        iss_instr  = ent_q[i].instr;
      end
    end
  end

  always_comb begin
    in_ready = cnt_q < DEPTH_C;
    in_fire  = in_valid && in_ready;
    iss_fire = iss_valid && iss_ready;
    cnt_post = cnt_q - {4'd0, iss_fire};
    cnt_d    = cnt_post + {4'd0, in_fire};

    new_e.op    = in_opcode;
    new_e.ps1   = in_ps1;
    new_e.ps2   = in_ps2;
    new_e.pd    = in_pd;
    new_e.instr = in_instr;
    new_e.r1    = no_rs1(in_opcode) || !busy_q[in_ps1] ||
                  (wb_valid && wb_preg == in_ps1);
    new_e.r2    = no_rs2(in_opcode) || !busy_q[in_ps2] ||
                  (wb_valid && wb_preg == in_ps2);

    // Slots at and above the issued one shift down; new entry lands at the tail
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (iss_fire && 5'(i) >= sel) ? ent_w[i+1] : ent_w[i];
      if (in_fire && 5'(i) == cnt_post)
        ent_d[i] = new_e;
    end

    busy_d = busy_q;
    if (wb_valid)
      busy_d[wb_preg] = 1'b0;
    if (in_fire && has_rd(in_opcode))
      busy_d[in_pd] = 1'b1;
  end

  assign count = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
    end else if (flush) begin
      cnt_q  <= '0;
      busy_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: queue-based reference model plus directed scenarios.
// Honours RS_WAKEUP_BYPASS_EN when the build defines it.
module tb_reservation_station;

  localparam int DEPTH = 8;
  localparam logic [6:0] ADDI  = 7'b0010011;
  localparam logic [6:0] ADD   = 7'b0110011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] LUI   = 7'b0110111;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [5:0]  in_ps1, in_ps2, in_pd;
  logic [31:0] in_instr;
  logic        wb_valid;
  logic [5:0]  wb_preg;
  logic        iss_valid, iss_ready;
  logic [6:0]  iss_opcode;
  logic [5:0]  iss_ps1, iss_ps2, iss_pd;
  logic [31:0] iss_instr;
  logic        flush;
  logic [4:0]  count;

  reservation_station #(.DEPTH(DEPTH), .NUM_PREGS(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_ps1(in_ps1), .in_ps2(in_ps2),
    .in_pd(in_pd), .in_instr(in_instr),
    .wb_valid(wb_valid), .wb_preg(wb_preg),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_opcode(iss_opcode), .iss_ps1(iss_ps1), .iss_ps2(iss_ps2),
    .iss_pd(iss_pd), .iss_instr(iss_instr),
    .flush(flush), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit [6:0]  op;
    bit [5:0]  ps1, ps2, pd;
    bit [31:0] instr;
    bit        r1, r2;
  } m_t;

  m_t q[$];
  bit busy [64];
  int m_sel;
  bit m_inf, m_isf;
  m_t m_new;

  function automatic bit m_no1(input bit [6:0] op);
    return op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111;
  endfunction
  function automatic bit m_no2(input bit [6:0] op);
    return m_no1(op) || op == 7'b0010011 || op == 7'b0000011 ||
           op == 7'b1100111;
  endfunction
  function automatic bit m_wr(input bit [6:0] op);
    return op != 7'b0100011 && op != 7'b1100011;
  endfunction
  function automatic bit m_rdy(input m_t e);
`ifdef RS_WAKEUP_BYPASS_EN
    return (e.r1 || (wb_valid && e.ps1 == wb_preg)) &&
           (e.r2 || (wb_valid && e.ps2 == wb_preg));
`else
    return e.r1 && e.r2;
`endif
  endfunction

  // Reference model: compare at negedge, then advance to the state after the next edge
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      foreach (busy[i]) busy[i] = 1'b0;
      chk("rst_count", 64'(count), 0);
      chk("rst_in_ready", 64'(in_ready), 1);
      chk("rst_iss_valid", 64'(iss_valid), 0);
    end else begin
      m_sel = -1;
      for (int i = 0; i < q.size(); i++)
        if (m_sel < 0 && m_rdy(q[i])) m_sel = i;
      chk("count", 64'(count), 64'(q.size()));
      chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      chk("iss_valid", 64'(iss_valid), 64'(m_sel >= 0));
      if (m_sel >= 0) begin
        chk("iss_opcode", 64'(iss_opcode), 64'(q[m_sel].op));
        chk("iss_ps1", 64'(iss_ps1), 64'(q[m_sel].ps1));
        chk("iss_ps2", 64'(iss_ps2), 64'(q[m_sel].ps2));
        chk("iss_pd", 64'(iss_pd), 64'(q[m_sel].pd));
        chk("iss_instr", 64'(iss_instr), 64'(q[m_sel].instr));
      end
      m_inf = in_valid && q.size() < DEPTH;
      m_isf = m_sel >= 0 && iss_ready;
      if (flush) begin
        q.delete();
        foreach (busy[i]) busy[i] = 1'b0;
      end else begin
        m_new.op = in_opcode;
        m_new.ps1 = in_ps1;
        m_new.ps2 = in_ps2;
        m_new.pd = in_pd;
        m_new.instr = in_instr;
        m_new.r1 = m_no1(in_opcode) || !busy[in_ps1] ||
                   (wb_valid && wb_preg == in_ps1);
        m_new.r2 = m_no2(in_opcode) || !busy[in_ps2] ||
                   (wb_valid && wb_preg == in_ps2);
        if (wb_valid)
          foreach (q[i]) begin
            if (q[i].ps1 == wb_preg) q[i].r1 = 1'b1;
            if (q[i].ps2 == wb_preg) q[i].r2 = 1'b1;
          end
        if (m_isf) q.delete(m_sel);
        if (wb_valid) busy[wb_preg] = 1'b0;
        if (m_inf) begin
          q.push_back(m_new);
          if (m_wr(in_opcode)) busy[in_pd] = 1'b1;
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [6:0] op, input logic [5:0] a,
                     input logic [5:0] b, input logic [5:0] d,
                     input logic [31:0] w);
    in_valid = 1'b1;
    in_opcode = op;
    in_ps1 = a;
    in_ps2 = b;
    in_pd = d;
    in_instr = w;
    nxt();
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    nxt();
    flush = 1'b0;
  endtask

  task automatic wake(input logic [5:0] t);
    wb_valid = 1'b1;
    wb_preg = t;
    nxt();
    wb_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_opcode = '0;
    in_ps1 = '0;
    in_ps2 = '0;
    in_pd = '0;
    in_instr = '0;
    wb_valid = 1'b0;
    wb_preg = '0;
    iss_ready = 1'b0;
    flush = 1'b0;
    repeat (2) nxt();
    @(negedge clk);
    chk("L_reset_count", 64'(count), 0);
    chk("L_reset_in_ready", 64'(in_ready), 1);
    chk("L_reset_iss_valid", 64'(iss_valid), 0);
    nxt();
    rst = 1'b0;

    // single independent addi
    iss_ready = 1'b1;
    ins(ADDI, 6'd3, 6'd0, 6'd7, 32'h0031_8393);
    @(negedge clk);
    chk("L_addi_valid", 64'(iss_valid), 1);
    chk("L_addi_pd", 64'(iss_pd), 7);
    chk("L_addi_count1", 64'(count), 1);
    nxt();
    @(negedge clk);
    chk("L_addi_count0", 64'(count), 0);
    nxt();
    do_flush();

    // dependent pair woken by writeback
    iss_ready = 1'b1;
    ins(ADDI, 6'd1, 6'd0, 6'd5, 32'hA);
    ins(ADD, 6'd5, 6'd2, 6'd6, 32'hB);
    @(negedge clk);
    chk("L_dep_wait_valid", 64'(iss_valid), 0);
    chk("L_dep_wait_count", 64'(count), 1);
    repeat (3) nxt();
    @(negedge clk);
    chk("L_dep_still_wait", 64'(iss_valid), 0);
    nxt();
    wb_valid = 1'b1;
    wb_preg = 6'd5;
    @(negedge clk);
`ifdef RS_WAKEUP_BYPASS_EN
    chk("L_dep_wake_cycle", 64'(iss_valid), 1);
`else
    chk("L_dep_wake_cycle", 64'(iss_valid), 0);
`endif
    nxt();
    wb_valid = 1'b0;
    @(negedge clk);
`ifdef RS_WAKEUP_BYPASS_EN
    chk("L_dep_after_count", 64'(count), 0);
`else
    chk("L_dep_after_valid", 64'(iss_valid), 1);
    chk("L_dep_after_pd", 64'(iss_pd), 6);
`endif
    nxt();
    do_flush();

    // fill to DEPTH, overflow ignored, drain in order
    iss_ready = 1'b0;
    for (int k = 0; k < 8; k++)
      ins(ADDI, 6'(10 + k), 6'd0, 6'(20 + k), 32'(k));
    @(negedge clk);
    chk("L_full_count", 64'(count), 8);
    chk("L_full_in_ready", 64'(in_ready), 0);
    nxt();
    ins(ADDI, 6'd1, 6'd0, 6'd40, 32'd99);
    @(negedge clk);
    chk("L_full_ignored", 64'(count), 8);
    nxt();
    iss_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("L_drain_pd", 64'(iss_pd), 64'(20 + k));
      nxt();
    end
    iss_ready = 1'b0;
    @(negedge clk);
    chk("L_drain_count", 64'(count), 0);
    nxt();
    do_flush();

    // younger ready entry bypasses older waiters
    iss_ready = 1'b1;
    ins(ADDI, 6'd1, 6'd0, 6'd30, 32'h30);
    ins(ADDI, 6'd1, 6'd0, 6'd31, 32'h31);
    nxt();
    iss_ready = 1'b0;
    ins(ADD, 6'd30, 6'd1, 6'd32, 32'h32);
    ins(ADD, 6'd31, 6'd1, 6'd33, 32'h33);
    ins(ADDI, 6'd2, 6'd0, 6'd34, 32'h34);
    @(negedge clk);
    chk("L_ooo_valid", 64'(iss_valid), 1);
    chk("L_ooo_pd", 64'(iss_pd), 34);
    chk("L_ooo_count", 64'(count), 3);
    nxt();
    iss_ready = 1'b1;
    nxt();
    iss_ready = 1'b0;
    @(negedge clk);
    chk("L_ooo_count2", 64'(count), 2);
    chk("L_ooo_none", 64'(iss_valid), 0);
    nxt();
    wake(6'd30);
    @(negedge clk);
    chk("L_ooo_e0_pd", 64'(iss_pd), 32);
    nxt();
    wake(6'd31);
    @(negedge clk);
    chk("L_ooo_e0_oldest", 64'(iss_pd), 32);
    nxt();
    iss_ready = 1'b1;
    @(negedge clk);
    chk("L_ooo_first", 64'(iss_pd), 32);
    nxt();
    @(negedge clk);
    chk("L_ooo_second", 64'(iss_pd), 33);
    nxt();
    iss_ready = 1'b0;
    do_flush();

    // insert-time wakeup capture, new producer wins, store and lui
    iss_ready = 1'b1;
    ins(ADDI, 6'd1, 6'd0, 6'd9, 32'h9);
    nxt();
    wb_valid = 1'b1;
    wb_preg = 6'd9;
    ins(ADD, 6'd1, 6'd9, 6'd35, 32'h35);
    wb_valid = 1'b0;
    @(negedge clk);
    chk("L_cap_valid", 64'(iss_valid), 1);
    chk("L_cap_pd", 64'(iss_pd), 35);
    nxt();
    wb_valid = 1'b1;
    wb_preg = 6'd12;
    ins(ADDI, 6'd1, 6'd0, 6'd12, 32'h12);
    wb_valid = 1'b0;
    ins(ADD, 6'd12, 6'd1, 6'd36, 32'h36);
    @(negedge clk);
    chk("L_newprod_wait", 64'(iss_valid), 0);
    chk("L_newprod_count", 64'(count), 1);
    nxt();
    ins(STORE, 6'd1, 6'd2, 6'd13, 32'h13);
    ins(ADD, 6'd13, 6'd1, 6'd37, 32'h37);
    @(negedge clk);
    chk("L_store_nobusy", 64'(iss_pd), 37);
    nxt();
    ins(LUI, 6'd12, 6'd12, 6'd38, 32'h38);
    @(negedge clk);
    chk("L_lui_ready", 64'(iss_pd), 38);
    nxt();
    do_flush();

    // flush beats insert; busy table cleared
    iss_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      ins(ADDI, 6'd1, 6'd0, 6'(40 + k), 32'(40 + k));
    flush = 1'b1;
    in_valid = 1'b1;
    in_opcode = ADDI;
    in_ps1 = 6'd1;
    in_pd = 6'd45;
    nxt();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("L_flush_count", 64'(count), 0);
    chk("L_flush_iss", 64'(iss_valid), 0);
    nxt();
    iss_ready = 1'b1;
    ins(ADD, 6'd40, 6'd45, 6'd46, 32'h46);
    @(negedge clk);
    chk("L_flush_busy_clr", 64'(iss_valid), 1);
    chk("L_flush_busy_pd", 64'(iss_pd), 46);
    nxt();

    // reset mid-stream
    iss_ready = 1'b0;
    ins(ADDI, 6'd1, 6'd0, 6'd50, 32'h50);
    ins(ADDI, 6'd1, 6'd0, 6'd51, 32'h51);
    ins(ADD, 6'd50, 6'd51, 6'd52, 32'h52);
    rst = 1'b1;
    @(negedge clk);
    chk("L_mrst_count", 64'(count), 0);
    chk("L_mrst_in_ready", 64'(in_ready), 1);
    chk("L_mrst_iss", 64'(iss_valid), 0);
    nxt();
    rst = 1'b0;
    iss_ready = 1'b1;
    ins(ADD, 6'd50, 6'd51, 6'd53, 32'h53);
    @(negedge clk);
    chk("L_mrst_first_valid", 64'(iss_valid), 1);
    chk("L_mrst_first_pd", 64'(iss_pd), 53);
    chk("L_mrst_first_count", 64'(count), 1);
    nxt();
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
